// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// The master side is the controller: it reads instruction fields and status
// and drives every enable, mux select and debug output.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic       illegal;
    logic [3:0] state_o;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, RegWrite, ImmSrc, illegal, state_o
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, RegWrite, ImmSrc, illegal, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM and ALU decoder for the multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type,
// I-type ALU, beq and jal, stalls on mem_ready during memory accesses and
// traps (or skips) unsupported opcodes. ImmSrc is decoded straight from op.
module multicycle_controller #(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state_q;
    state_t     state_d;
    alu_op_t    alu_op;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;

    // State register; reset lands in FETCH at once, even mid-instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and Moore control decode (FETCH enables gated by mem_ready).
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d    = state_q;
        alu_op     = ALU_OP_ADD;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.mem_ready;
                pc_update  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = ILLEGAL_TRAP ? S_ILLEGAL : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                // Only lw and sw reach here; op[5] tells them apart.
                state_d   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_OP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALU_OP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_OP_SUB;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
    end

    // ALU decoder: fixed add/sub, or the operation selected by funct3/funct7.
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            ALU_OP_SUB: alu_control = 3'b001;
            ALU_OP_FUNCT: begin
                case (bus.funct3)
                    3'b000:  alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    // Immediate format for the extender, straight from the opcode.
    always_comb begin
        case (bus.op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign bus.PCWrite    = pc_update | (branch & bus.Zero);
    assign bus.AdrSrc     = adr_src;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegWrite   = reg_write;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = imm_src;
    assign bus.illegal    = (state_q == S_ILLEGAL);
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each planned cycle pushes
// its stimulus and the expected state/control word onto queues; the drain
// loop applies the stimulus and compares at the falling edge.
module tb_multicycle_controller;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                           MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7,
                           ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, ILLEGAL = 4'd11;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;

    always #5 clk = ~clk;

    multicycle_controller_if ifc ();
    multicycle_controller_if ifc2 ();

    multicycle_controller #(.ILLEGAL_TRAP(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    multicycle_controller #(.ILLEGAL_TRAP(1'b0)) dut_nop (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (ifc2)
    );

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [16:0] ctl;
    } exp_t;

    typedef struct {
        logic mr;
        logic zr;
    } stim_t;

    exp_t  exp_q[$];
    stim_t stim_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    logic [16:0] ctl_now;
    assign ctl_now = {ifc.PCWrite, ifc.AdrSrc, ifc.MemWrite, ifc.IRWrite, ifc.RegWrite,
                      ifc.ResultSrc, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUControl,
                      ifc.ImmSrc, ifc.illegal};

    // Expected control word for a state, built from the state table.
    function automatic logic [16:0] exp_ctl(input logic [3:0] st, input logic mr,
                                            input logic zr, input logic [2:0] alu_f,
                                            input logic [1:0] imm);
        logic       pcw = 1'b0, adr = 1'b0, memw = 1'b0, irw = 1'b0, regw = 1'b0, ill = 1'b0;
        logic [1:0] rsrc = 2'b00, srca = 2'b00, srcb = 2'b00;
        logic [2:0] alu = 3'b000;
        case (st)
            FETCH:    begin rsrc = 2'b10; srcb = 2'b10; irw = mr; pcw = mr; end
            DECODE:   begin srca = 2'b01; srcb = 2'b01; end
            MEMADR:   begin srca = 2'b10; srcb = 2'b01; end
            MEMREAD:  begin adr = 1'b1; end
            MEMWB:    begin rsrc = 2'b01; regw = 1'b1; end
            MEMWRITE: begin adr = 1'b1; memw = 1'b1; end
            EXECUTER: begin srca = 2'b10; alu = alu_f; end
            EXECUTEI: begin srca = 2'b10; srcb = 2'b01; alu = alu_f; end
            ALUWB:    begin regw = 1'b1; end
            BEQ:      begin srca = 2'b10; alu = 3'b001; pcw = zr; end
            JAL:      begin srca = 2'b01; srcb = 2'b10; pcw = 1'b1; end
            ILLEGAL:  begin ill = 1'b1; end
            default:  ;
        endcase
        return {pcw, adr, memw, irw, regw, rsrc, srca, srcb, alu, imm, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic plan(input string name, input logic [3:0] st, input logic mr,
                        input logic zr, input logic [2:0] alu_f, input logic [1:0] imm);
        exp_t  e;
        stim_t s;
        s.mr   = mr;
        s.zr   = zr;
        e.name = name;
        e.st   = st;
        e.ctl  = exp_ctl(st, mr, zr, alu_f, imm);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Apply queued stimulus one cycle at a time; entered at posedge+1.
    task automatic drain();
        stim_t s;
        exp_t  e;
        int    idx = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            ifc.mem_ready = s.mr;
            ifc.Zero      = s.zr;
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("%s[%0d].state", e.name, idx), {28'd0, ifc.state_o}, {28'd0, e.st});
            check($sformatf("%s[%0d].ctl", e.name, idx), {15'd0, ctl_now}, {15'd0, e.ctl});
            idx++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        ifc.op       = op;
        ifc.funct3   = f3;
        ifc.funct7b5 = f7;
    endtask

    // Standard R/I ALU instruction: FETCH, DECODE, EXECUTE, ALUWB.
    task automatic alu_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic [2:0] alu_exp);
        set_instr(op, f3, f7);
        plan(name, FETCH, 1'b1, 1'b0, 3'b000, 2'b00);
        plan(name, DECODE, 1'b1, 1'b0, 3'b000, 2'b00);
        plan(name, op[5] ? EXECUTER : EXECUTEI, 1'b1, 1'b0, alu_exp, 2'b00);
        plan(name, ALUWB, 1'b1, 1'b0, 3'b000, 2'b00);
        drain();
    endtask

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);
        ifc.mem_ready  = 1'b0;
        ifc.Zero       = 1'b0;
        ifc2.op        = 7'b0110111;
        ifc2.funct3    = 3'b000;
        ifc2.funct7b5  = 1'b0;
        ifc2.mem_ready = 1'b1;
        ifc2.Zero      = 1'b0;

        // Reset: FETCH decode with enables gated off by mem_ready=0.
        #1;
        check("rst.state", {28'd0, ifc.state_o}, 32'd0);
        check("rst.ctl_mr0", {15'd0, ctl_now}, {15'd0, exp_ctl(FETCH, 1'b0, 1'b0, 3'b000, 2'b00)});
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst.hold_state", {28'd0, ifc.state_o}, 32'd0);
        ifc.mem_ready = 1'b1;
        #1;
        check("rst.ctl_mr1", {15'd0, ctl_now}, {15'd0, exp_ctl(FETCH, 1'b1, 1'b0, 3'b000, 2'b00)});
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // add: 0,1,6,8
        alu_instr("add", 7'b0110011, 3'b000, 1'b0, 3'b000);

        // lw with two stall cycles in MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0);
        plan("lw", FETCH, 1'b1, 1'b0, 3'b000, 2'b00);
        plan("lw", DECODE, 1'b1, 1'b0, 3'b000, 2'b00);
        plan("lw", MEMADR, 1'b1, 1'b0, 3'b000, 2'b00);
        plan("lw", MEMREAD, 1'b0, 1'b0, 3'b000, 2'b00);
        plan("lw", MEMREAD, 1'b0, 1'b0, 3'b000, 2'b00);
        plan("lw", MEMREAD, 1'b1, 1'b0, 3'b000, 2'b00);
        plan("lw", MEMWB, 1'b1, 1'b0, 3'b000, 2'b00);
        drain();

        // sw with a fetch stall and a write stall
        set_instr(7'b0100011, 3'b010, 1'b0);
        plan("sw", FETCH, 1'b0, 1'b0, 3'b000, 2'b01);
        plan("sw", FETCH, 1'b1, 1'b0, 3'b000, 2'b01);
        plan("sw", DECODE, 1'b1, 1'b0, 3'b000, 2'b01);
        plan("sw", MEMADR, 1'b1, 1'b0, 3'b000, 2'b01);
        plan("sw", MEMWRITE, 1'b0, 1'b0, 3'b000, 2'b01);
        plan("sw", MEMWRITE, 1'b1, 1'b0, 3'b000, 2'b01);
        drain();

        // beq taken and not taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        plan("beq_t", FETCH, 1'b1, 1'b0, 3'b000, 2'b10);
        plan("beq_t", DECODE, 1'b1, 1'b0, 3'b000, 2'b10);
        plan("beq_t", BEQ, 1'b1, 1'b1, 3'b000, 2'b10);
        plan("beq_n", FETCH, 1'b1, 1'b0, 3'b000, 2'b10);
        plan("beq_n", DECODE, 1'b1, 1'b0, 3'b000, 2'b10);
        plan("beq_n", BEQ, 1'b1, 1'b0, 3'b000, 2'b10);
        drain();

        // ALU decoder cases
        alu_instr("sub", 7'b0110011, 3'b000, 1'b1, 3'b001);
        alu_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 3'b000);
        alu_instr("slt", 7'b0110011, 3'b010, 1'b0, 3'b101);
        alu_instr("ori", 7'b0010011, 3'b110, 1'b0, 3'b011);
        alu_instr("and", 7'b0110011, 3'b111, 1'b0, 3'b010);
        alu_instr("sll", 7'b0110011, 3'b001, 1'b0, 3'b000);

        // jal: 0,1,10,8
        set_instr(7'b1101111, 3'b000, 1'b0);
        plan("jal", FETCH, 1'b1, 1'b0, 3'b000, 2'b11);
        plan("jal", DECODE, 1'b1, 1'b0, 3'b000, 2'b11);
        plan("jal", JAL, 1'b1, 1'b0, 3'b000, 2'b11);
        plan("jal", ALUWB, 1'b1, 1'b0, 3'b000, 2'b11);
        drain();

        // jal interrupted by reset while in JAL
        plan("jal_rst", FETCH, 1'b1, 1'b0, 3'b000, 2'b11);
        plan("jal_rst", DECODE, 1'b1, 1'b0, 3'b000, 2'b11);
        drain();
        @(negedge clk);
        check("jal_rst.in_jal", {28'd0, ifc.state_o}, {28'd0, JAL});
        check("jal_rst.pcwrite", {31'd0, ifc.PCWrite}, 32'd1);
        #2;
        ifc.mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("jal_rst.async_state", {28'd0, ifc.state_o}, 32'd0);
        check("jal_rst.async_ctl", {15'd0, ctl_now},
              {15'd0, exp_ctl(FETCH, 1'b0, 1'b0, 3'b000, 2'b11)});
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lui traps into ILLEGAL and stays
        set_instr(7'b0110111, 3'b000, 1'b0);
        plan("lui", FETCH, 1'b1, 1'b0, 3'b000, 2'b00);
        plan("lui", DECODE, 1'b1, 1'b0, 3'b000, 2'b00);
        for (int i = 0; i < 12; i++) plan("lui", ILLEGAL, 1'b1, 1'b0, 3'b000, 2'b00);
        drain();
        rst_n = 1'b0;
        #1;
        check("lui.async_state", {28'd0, ifc.state_o}, 32'd0);
        check("lui.illegal_clr", {31'd0, ifc.illegal}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lui with trapping disabled returns to FETCH
        rst2_n = 1'b1;
        @(negedge clk);
        check("nop.fetch", {28'd0, ifc2.state_o}, 32'd0);
        @(negedge clk);
        check("nop.decode", {28'd0, ifc2.state_o}, 32'd1);
        @(negedge clk);
        check("nop.back_fetch", {28'd0, ifc2.state_o}, 32'd0);
        check("nop.illegal", {31'd0, ifc2.illegal}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
